// File: rtl/arm_ctrl_pkg.sv
// Shared ARM controller definitions: condition codes, NZCV bit positions, FlagW bits.
// Used by the decoder, this conditional back end and the future multicycle controller.
package arm_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the {N,Z,C,V} flag nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // FlagW[1] writes N,Z; FlagW[0] writes C,V
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/datapath-facing bundle of the conditional back end.
// master = decoder side driving requests, slave = cond_logic.
interface cond_logic_if #(parameter int CNT_W = 16);
  logic             en;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             clr_cnt;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, clr_cnt,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, exec_cnt, squash_cnt
  );

  modport slave (
    input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, clr_cnt,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, exec_cnt, squash_cnt
  );
endinterface

// File: rtl/cond_logic_cond_check.sv
// Purely combinational ARM condition-code evaluator: (Cond, NZCV) -> pass.
// Kept standalone so a pipelined hazard unit can reuse it.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;  // NV: never executes
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution back end: NZCV register, condition-gated write strobes,
// saturating executed/squashed instruction counters.
module cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  cond_logic_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q;
  logic             cond_pass;
  logic             cond_ex;
  logic             squash;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  // Evaluated against the registered flags only: no ALUFlags bypass
  cond_check u_cond_check (
    .cond      (bus.Cond),
    .flags     (flags_q),
    .cond_pass (cond_pass)
  );

  assign cond_ex = bus.en & cond_pass;
  assign squash  = bus.en & ~cond_pass;

  assign bus.CondEx     = cond_ex;
  assign bus.PCSrc      = bus.PCS  & cond_ex;
  assign bus.RegWrite   = bus.RegW & cond_ex;
  assign bus.MemWrite   = bus.MemW & cond_ex;
  assign bus.Flags      = flags_q;
  assign bus.exec_cnt   = exec_q;
  assign bus.squash_cnt = squash_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (cond_ex) begin
      if (bus.FlagW[FLAGW_NZ])
        flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (bus.FlagW[FLAGW_CV])
        flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Clear beats increment; both counters stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      if (bus.clr_cnt)
        exec_q <= '0;
      else if (cond_ex && exec_q != CNT_MAX)
        exec_q <= exec_q + CNT_ONE;

      if (bus.clr_cnt)
        squash_q <= '0;
      else if (squash && squash_q != CNT_MAX)
        squash_q <= squash_q + CNT_ONE;
    end
  end

endmodule
